ascon_bdo_buf: RTL

- Elastic output stage between the Ascon core block-data-out stream (bdo, bdo_type, bdo_eot) and the OBI write-DMA word stream.
- Filters words by data type, buffers up to DEPTH words, and marks end-of-type as a last flag.
- Keeps forwarded/dropped word counters and completion flags for the control/status register word.
- Decouples core stalls from OBI bus latency.

---
 rtl/ascon_bdo_buf.sv | 107 ++++++++++
 1 files changed

// File: rtl/ascon_bdo_buf.sv
// Ascon block-data-out elastic buffer: type filter, FIFO and status counters.
// Sits between the core bdo stream and the OBI write-DMA word stream.
module ascon_bdo_buf #(
    parameter int DEPTH = 8,
    parameter int DW    = 32,
    parameter int CW    = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic [15:0]                type_mask_i,
    input  logic                       s_valid_i,
    output logic                       s_ready_o,
    input  logic [DW-1:0]              s_data_i,
    input  logic [3:0]                 s_type_i,
    input  logic                       s_eot_i,
    output logic                       m_valid_o,
    input  logic                       m_ready_i,
    output logic [DW-1:0]              m_data_o,
    output logic                       m_last_o,
    output logic [$clog2(DEPTH):0]     level_o,
    output logic [CW-1:0]              fwd_cnt_o,
    output logic [7:0]                 drop_cnt_o,
    output logic                       eot_seen_o,
    output logic                       done_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL = LW'(DEPTH);

    logic [DW:0]    mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [LW-1:0]  level;
    logic [CW-1:0]  fwd_cnt;
    logic [7:0]     drop_cnt;
    logic           eot_seen;
    logic           done;
    logic           clr;
    logic           match;
    logic           push;
    logic           drop;
    logic           pop;

    assign clr   = rst_i || flush_i;
    assign match = type_mask_i[s_type_i];

    // Ready uses only registered level, so no path from m_ready_i.
    assign s_ready_o = !clr && (!match || (level != FULL));
    assign push      = s_valid_i && s_ready_o && match;
    assign drop      = s_valid_i && s_ready_o && !match;

    assign m_valid_o = (level != '0);
    assign pop       = m_valid_o && m_ready_i && !clr;
    assign m_data_o  = mem[rd_ptr][DW:1];
    assign m_last_o  = m_valid_o && mem[rd_ptr][0];

    assign level_o    = level;
    assign fwd_cnt_o  = fwd_cnt;
    assign drop_cnt_o = drop_cnt;
    assign eot_seen_o = eot_seen;
    assign done_o     = done;

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr] <= {s_data_i, s_eot_i};
        end
    end

    always_ff @(posedge clk_i) begin
        if (clr) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            fwd_cnt  <= '0;
            drop_cnt <= '0;
            eot_seen <= 1'b0;
            done     <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
            if (push && (fwd_cnt != '1)) begin
                fwd_cnt <= fwd_cnt + 1'b1;
            end
            if (push && s_eot_i) begin
                eot_seen <= 1'b1;
            end
            if (drop && (drop_cnt != 8'hFF)) begin
                drop_cnt <= drop_cnt + 1'b1;
            end
            if (pop && m_last_o) begin
                done <= 1'b1;
            end
        end
    end

endmodule
